// File: rtl/router_fsm_np.sv
// router_fsm_np: control FSM for the N-port router.
// Decodes the destination from the header byte and sequences header, payload and
// parity loading into the register block. It also handles FIFO-full back-pressure,
// drops packets with an invalid address and aborts on the destination's soft reset.
//
// Optional build macro: ROUTER_FSM_TIMEOUT_EN.
// When it is defined, WAIT_EMPTY gives up after WAIT_TIMEOUT cycles and the packet
// is dropped. When it is not defined, WAIT_EMPTY waits indefinitely and timeout_err
// stays 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   pkt_valid, data_in       input bus control and address field
//   fifo_empty, fifo_full    per-port empty flags, full flag of the selected FIFO
//   low_pkt_valid            register block status: pkt_valid has fallen
//   parity_done              register block status: parity byte finished
//   soft_reset               per-port soft reset from the FIFOs
//   detect_add .. drop_state registered state decodes
//   busy, write_en_reg       registered state decodes
//   dest_sel                 latched one-hot destination (0 in DECODE/DROP)
//   timeout_err              one-cycle pulse when WAIT_EMPTY times out
module router_fsm_np #(
    parameter int unsigned NUM_PORTS    = 3,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic                 fifo_full,
    input  logic                 low_pkt_valid,
    input  logic                 parity_done,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic                 write_en_reg,
    output logic                 drop_state,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 timeout_err
);

    typedef enum logic [3:0] {
        DECODE          = 4'd0,
        LOAD_FIRST      = 4'd1,
        WAIT_EMPTY      = 4'd2,
        LOAD_DATA       = 4'd3,
        LOAD_PARITY     = 4'd4,
        FIFO_FULL       = 4'd5,
        LOAD_AFTER_FULL = 4'd6,
        CHECK_PARITY    = 4'd7,
        DROP            = 4'd8
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic                addr_ok;
    logic                hdr_empty;
    logic                dest_empty;
    logic                dest_srst;
    logic                wait_expired;
    logic                timeout_d;
    logic [NUM_PORTS-1:0] dest_onehot;

    logic detect_add_d, lfd_state_d, ld_state_d, full_state_d, laf_state_d;
    logic rst_int_reg_d, busy_d, write_en_reg_d, drop_state_d;

    assign addr_ok = (32'(data_in) < NUM_PORTS);

    // Per-port lookups through the live header address and the latched destination.
    always_comb begin
        hdr_empty  = 1'b0;
        dest_empty = 1'b0;
        dest_srst  = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (data_in == ADDR_W'(p)) begin
                hdr_empty = fifo_empty[p];
            end
            if (dest_q == ADDR_W'(p)) begin
                dest_empty = fifo_empty[p];
                dest_srst  = soft_reset[p];
            end
        end
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Cycles spent in WAIT_EMPTY; held at zero elsewhere, so it is clear on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT_EMPTY) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign wait_expired = (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
`else
    assign wait_expired = 1'b0;
`endif

    // Next state, latched destination and output decodes of the next state.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        timeout_d = 1'b0;

        case (state_q)
            DECODE: begin
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        state_d = DROP;
                    end else begin
                        dest_d  = data_in;
                        state_d = hdr_empty ? LOAD_FIRST : WAIT_EMPTY;
                    end
                end
            end
            LOAD_FIRST: state_d = LOAD_DATA;
            WAIT_EMPTY: begin
                // A FIFO draining in the timeout cycle still wins.
                if (dest_empty) begin
                    state_d = LOAD_FIRST;
                end else if (wait_expired) begin
                    state_d   = DROP;
                    timeout_d = 1'b1;
                end
            end
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            LOAD_PARITY:  state_d = CHECK_PARITY;
            CHECK_PARITY: state_d = fifo_full ? FIFO_FULL : DECODE;
            FIFO_FULL: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            DROP: begin
                if (!pkt_valid) begin
                    state_d = DECODE;
                end
            end
            default: state_d = DECODE;
        endcase

        // Soft reset of the destination FIFO aborts the packet ahead of everything else.
        if ((state_q != DECODE) && (state_q != DROP) && dest_srst) begin
            state_d   = DECODE;
            timeout_d = 1'b0;
        end

        detect_add_d    = (state_d == DECODE);
        lfd_state_d     = (state_d == LOAD_FIRST);
        ld_state_d      = (state_d == LOAD_DATA);
        full_state_d    = (state_d == FIFO_FULL);
        laf_state_d     = (state_d == LOAD_AFTER_FULL);
        rst_int_reg_d   = (state_d == CHECK_PARITY);
        drop_state_d    = (state_d == DROP);
        busy_d          = (state_d == LOAD_FIRST) || (state_d == WAIT_EMPTY) ||
                          (state_d == LOAD_PARITY) || (state_d == FIFO_FULL) ||
                          (state_d == LOAD_AFTER_FULL);
        write_en_reg_d  = (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                          (state_d == LOAD_AFTER_FULL);
    end

    // One-hot of the destination that will be held after this edge.
    always_comb begin
        dest_onehot = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            dest_onehot[p] = (dest_d == ADDR_W'(p));
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= DECODE;
            dest_q       <= '0;
            detect_add   <= 1'b1;
            lfd_state    <= 1'b0;
            ld_state     <= 1'b0;
            full_state   <= 1'b0;
            laf_state    <= 1'b0;
            rst_int_reg  <= 1'b0;
            busy         <= 1'b0;
            write_en_reg <= 1'b0;
            drop_state   <= 1'b0;
            dest_sel     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dest_q       <= dest_d;
            detect_add   <= detect_add_d;
            lfd_state    <= lfd_state_d;
            ld_state     <= ld_state_d;
            full_state   <= full_state_d;
            laf_state    <= laf_state_d;
            rst_int_reg  <= rst_int_reg_d;
            busy         <= busy_d;
            write_en_reg <= write_en_reg_d;
            drop_state   <= drop_state_d;
            dest_sel     <= ((state_d == DECODE) || (state_d == DROP)) ? '0 : dest_onehot;
            timeout_err  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_router_fsm_np.sv
// tb_router_fsm_np: directed and randomized checks of router_fsm_np.
// Each packet scenario is expanded into a per-cycle trace of inputs and the
// packet phase the router must show after that clock edge.
// Expected outputs are then decoded from that phase.
module tb_router_fsm_np;

    localparam int unsigned NUM_PORTS    = 3;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned WAIT_TIMEOUT = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic                 fifo_full;
    logic                 low_pkt_valid;
    logic                 parity_done;
    logic [NUM_PORTS-1:0] soft_reset;
    logic detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
    logic busy, write_en_reg, drop_state, timeout_err;
    logic [NUM_PORTS-1:0] dest_sel;

    router_fsm_np #(
        .NUM_PORTS   (NUM_PORTS),
        .ADDR_W      (ADDR_W),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .low_pkt_valid(low_pkt_valid),
        .parity_done  (parity_done),
        .soft_reset   (soft_reset),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .full_state   (full_state),
        .laf_state    (laf_state),
        .rst_int_reg  (rst_int_reg),
        .busy         (busy),
        .write_en_reg (write_en_reg),
        .drop_state   (drop_state),
        .dest_sel     (dest_sel),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Packet phases as seen on the outputs.
    typedef enum int {P_DEC, P_LF, P_WAIT, P_LD, P_LP, P_FULL, P_LAF, P_CP, P_DROP} phase_e;

    typedef struct {
        logic       pv;
        logic [1:0] data;
        logic [2:0] empty;
        logic       full;
        logic       lpv;
        logic       pd;
        logic [2:0] srst;
        phase_e     exp;
        logic       tmo;
        logic [1:0] dest;
    } step_t;

    step_t      q[$];
    phase_e     cur_ph;
    logic [1:0] cur_dest;
    int         ntests = 0;
    int         nfail  = 0;

    // Random inputs for one cycle; the destination's soft reset is kept low inside a packet.
    function automatic step_t mk();
        step_t s;
        s.pv    = 1'($urandom);
        s.data  = 2'($urandom);
        s.empty = 3'($urandom);
        s.full  = 1'($urandom);
        s.lpv   = 1'($urandom);
        s.pd    = 1'($urandom);
        s.srst  = 3'($urandom);
        if (cur_ph != P_DEC && cur_ph != P_DROP) s.srst[cur_dest] = 1'b0;
        s.exp   = P_DEC;
        s.tmo   = 1'b0;
        s.dest  = cur_dest;
        return s;
    endfunction

    task automatic push(input step_t s, input phase_e nxt);
        s.exp = nxt;
        q.push_back(s);
        cur_ph = nxt;
    endtask

    function automatic logic [12:0] exp_vec(input step_t s);
        phase_e     p;
        logic [2:0] ds;
        p  = s.exp;
        ds = (p == P_DEC || p == P_DROP) ? 3'b000 : (3'b001 << s.dest);
        return {p == P_DEC, p == P_LF, p == P_LD, p == P_FULL, p == P_LAF, p == P_CP,
                (p == P_LF || p == P_WAIT || p == P_LP || p == P_FULL || p == P_LAF),
                (p == P_LD || p == P_LP || p == P_LAF),
                p == P_DROP, s.tmo, ds};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
                busy, write_en_reg, drop_state, timeout_err, dest_sel};
    endfunction

    task automatic check(input string tag, input step_t s);
        logic [12:0] o, e;
        o = obs_vec();
        e = exp_vec(s);
        ntests++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, o, e);
        end
    endtask

    task automatic check_reset(input string tag);
        step_t s;
        s = mk();
        s.exp  = P_DEC;
        s.tmo  = 1'b0;
        s.dest = 2'd0;
        check(tag, s);
    endtask

    task automatic apply(input step_t s);
        pkt_valid     = s.pv;
        data_in       = s.data;
        fifo_empty    = s.empty;
        fifo_full     = s.full;
        low_pkt_valid = s.lpv;
        parity_done   = s.pd;
        soft_reset    = s.srst;
    endtask

    task automatic run_queue(input string tag);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            apply(s);
            @(posedge clk);
            #1;
            check(tag, s);
        end
    endtask

    task automatic idle();
        step_t s;
        s = mk();
        s.pv = 1'b0;
        push(s, P_DEC);
    endtask

    // Packet to d: w cycles waiting for empty, L load-data cycles, optional k-cycle
    // stall before the j-th byte, and one of three ways of finishing.
    task automatic gen_packet(input logic [1:0] d, input int L, input int w,
                              input int j, input int k, input int em);
        step_t s;
        int    ld;
        cur_dest = d;
        s = mk(); s.pv = 1'b1; s.data = d; s.empty[d] = (w == 0);
        push(s, (w == 0) ? P_LF : P_WAIT);
        for (int i = 1; i <= w; i++) begin
            s = mk(); s.empty[d] = (i == w);
            push(s, (i == w) ? P_LF : P_WAIT);
        end
        s = mk(); push(s, P_LD);
        ld = 1;
        while (ld < L) begin
            if (ld == j && k > 0) begin
                for (int i = 0; i < k; i++) begin
                    s = mk(); s.full = 1'b1; push(s, P_FULL);
                end
                s = mk(); s.full = 1'b0; push(s, P_LAF);
                s = mk(); s.pd = 1'b0; s.lpv = 1'b0; push(s, P_LD);
            end else begin
                s = mk(); s.pv = 1'b1; s.full = 1'b0; push(s, P_LD);
            end
            ld++;
        end
        if (em == 2) begin
            s = mk(); s.full = 1'b1; push(s, P_FULL);
            s = mk(); s.full = 1'b0; push(s, P_LAF);
            s = mk(); s.pd = 1'b0; s.lpv = 1'b1; push(s, P_LP);
            s = mk(); push(s, P_CP);
            s = mk(); s.full = 1'b0; push(s, P_DEC);
        end else begin
            s = mk(); s.pv = 1'b0; s.full = 1'b0; push(s, P_LP);
            s = mk(); push(s, P_CP);
            if (em == 1) begin
                s = mk(); s.full = 1'b1; push(s, P_FULL);
                s = mk(); s.full = 1'b0; push(s, P_LAF);
                s = mk(); s.pd = 1'b1; push(s, P_DEC);
            end else begin
                s = mk(); s.full = 1'b0; push(s, P_DEC);
            end
        end
    endtask

    task automatic gen_drop(input int n);
        step_t s;
        s = mk(); s.pv = 1'b1; s.data = 2'd3; push(s, P_DROP);
        for (int i = 0; i < n; i++) begin
            s = mk(); s.pv = 1'b1; push(s, P_DROP);
        end
        s = mk(); s.pv = 1'b0; push(s, P_DEC);
    endtask

    task automatic gen_timeout(input logic [1:0] d);
        step_t s;
        cur_dest = d;
        s = mk(); s.pv = 1'b1; s.data = d; s.empty[d] = 1'b0; push(s, P_WAIT);
`ifdef ROUTER_FSM_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            s = mk(); s.empty[d] = 1'b0; push(s, P_WAIT);
        end
        s = mk(); s.empty[d] = 1'b0; s.tmo = 1'b1; push(s, P_DROP);
        s = mk(); s.pv = 1'b1; push(s, P_DROP);
        s = mk(); s.pv = 1'b0; push(s, P_DEC);
`else
        for (int i = 0; i < 99; i++) begin
            s = mk(); s.empty[d] = 1'b0; push(s, P_WAIT);
        end
        s = mk(); s.srst[d] = 1'b1; push(s, P_DEC);
        s = mk(); s.pv = 1'b0; push(s, P_DEC);
`endif
    endtask

    // Destination soft reset at queue entry m; the rest of that packet is discarded.
    task automatic abort_at(input int m);
        step_t s;
        s = q[m];
        s.srst[s.dest] = 1'b1;
        s.exp = P_DEC;
        s.tmo = 1'b0;
        q[m] = s;
        while (q.size() > m + 1) void'(q.pop_back());
        cur_ph = P_DEC;
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        step_t s;
        int st, kind, nidle, L, w, j, k, em;
        logic [1:0] d;

        cur_ph   = P_DEC;
        cur_dest = 2'd0;
        rst      = 1'b0;
        s = mk();
        s.pv = 1'b1;
        apply(s);
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_hold");
        rst = 1'b1;

        gen_packet(2'd1, 4, 0, 0, 0, 0);
        run_queue("basic");

        gen_packet(2'd1, 6, 0, 2, 3, 0);
        run_queue("backpressure");

        gen_drop(3);
        run_queue("invalid_addr");

        gen_timeout(2'd0);
        run_queue("timeout");

        gen_packet(2'd0, 3, 4, 0, 0, 1);
        run_queue("wait_empty_tie");

        st = q.size();
        gen_packet(2'd2, 4, 0, 0, 0, 0);
        s = q[st + 2]; s.srst = 3'b011; q[st + 2] = s;
        abort_at(st + 3);
        run_queue("soft_reset_abort");

        for (int n = 0; n < 40; n++) begin
            kind  = int'($urandom_range(0, 9));
            nidle = int'($urandom_range(0, 2));
            for (int i = 0; i < nidle; i++) idle();
            d  = 2'($urandom_range(0, 2));
            L  = int'($urandom_range(1, 6));
            w  = int'($urandom_range(0, 4));
            j  = (L > 1) ? int'($urandom_range(1, 32'(L - 1))) : 0;
            k  = int'($urandom_range(0, 3));
            em = int'($urandom_range(0, 2));
            if (kind <= 5) begin
                gen_packet(d, L, w, j, k, em);
            end else if (kind == 6) begin
                gen_drop(int'($urandom_range(0, 3)));
            end else if (kind == 7) begin
                gen_timeout(d);
            end else begin
                st = q.size();
                gen_packet(d, L, w, j, k, em);
                abort_at(st + 1 + int'($urandom_range(0, 32'(q.size() - st - 2))));
            end
            run_queue("random");
        end

        // Drive into FIFO_FULL, then pulse reset low between clock edges.
        cur_dest = 2'd1;
        s = mk(); s.pv = 1'b1; s.data = 2'd1; s.empty = 3'b111; push(s, P_LF);
        s = mk(); push(s, P_LD);
        s = mk(); s.pv = 1'b1; s.full = 1'b0; push(s, P_LD);
        s = mk(); s.full = 1'b1; push(s, P_FULL);
        s = mk(); s.full = 1'b1; push(s, P_FULL);
        run_queue("pre_reset");
        fifo_full  = 1'b1;
        soft_reset = 3'b000;
        #3;
        rst = 1'b0;
        #1;
        check_reset("async_reset_immediate");
        @(posedge clk);
        #1;
        check_reset("async_reset_held");
        pkt_valid  = 1'b1;
        data_in    = 2'd1;
        fifo_empty = 3'b111;
        #2;
        rst    = 1'b1;
        cur_ph = P_DEC;
        gen_packet(2'd1, 2, 0, 0, 0, 0);
        run_queue("reset_release");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
